// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] FUNCT3_LW = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported instruction/data memory between the fetch
// port and the load/store port using a req/gnt/rvalid handshake. Data
// accesses win ties unless they have starved a pending fetch for
// MAX_D_BURST consecutive grants.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 1,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STREAK_W = $clog2(MAX_D_BURST + 1);

  localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LAT - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_BURST);

  arb_state_e          state_q, state_d;
  owner_e              owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STREAK_W-1:0] streak_q;
  logic                grant_if, grant_d;
  logic                access_done;

  assign access_done = (state_q == ARB_ACCESS) && (cnt_q == '0);
  assign if_gnt      = grant_if;
  assign d_gnt       = grant_d;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: leave IDLE on any grant, leave ACCESS when the hold expires.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:   if (grant_if || grant_d) state_d = ARB_ACCESS;
      ARB_ACCESS: if (access_done)         state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Grant decision: only in IDLE, fetch forced once the data streak saturates.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rst && state_q == ARB_IDLE) begin
      if (d_req && if_req && streak_q == STREAK_MAX) grant_if = 1'b1;
      else if (d_req)                                 grant_d  = 1'b1;
      else if (if_req)                                grant_if = 1'b1;
    end
  end

  // Access datapath: latch the winner onto the memory bus, hold it for
  // MEM_LAT cycles, then return read data to the owner with a one-cycle pulse.
  // mem_write doubles as the latched store flag for the completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_funct3 <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (grant_d) begin
        owner_q    <= OWN_D;
        cnt_q      <= CNT_INIT;
        mem_read   <= !d_we;
        mem_write  <= d_we;
        mem_funct3 <= d_funct3;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
        busy       <= 1'b1;
      end else if (grant_if) begin
        owner_q    <= OWN_IF;
        cnt_q      <= CNT_INIT;
        mem_read   <= 1'b1;
        mem_write  <= 1'b0;
        mem_funct3 <= FUNCT3_LW;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        busy       <= 1'b1;
      end else if (state_q == ARB_ACCESS) begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_IF) begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end else begin
            d_rdata  <= mem_write ? '0 : mem_rdata;
            d_rvalid <= 1'b1;
          end
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          mem_funct3 <= '0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          busy       <= 1'b0;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Starvation tracking: count data grants that bypassed a waiting fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else if (grant_if) begin
      streak_q <= '0;
    end else if (grant_d) begin
      if (!if_req)                  streak_q <= '0;
      else if (streak_q != STREAK_MAX) streak_q <= streak_q + STREAK_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (a_*)
// and one with MEM_LAT=3 (b_*), sharing clock, reset and request inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
  logic        a_mem_read, a_mem_write, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_wdata;
  logic [2:0]  a_mem_funct3;
  logic [7:0]  a_mem_addr;

  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
  logic        b_mem_read, b_mem_write, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata;
  logic [2:0]  b_mem_funct3;
  logic [7:0]  b_mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .MAX_D_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_funct3(a_mem_funct3),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
    .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .MAX_D_BURST(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_funct3(b_mem_funct3),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
    .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #1 rst = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    #2;
    checks++;
    if ({a_if_gnt, a_d_gnt, a_mem_read, a_mem_write, a_busy, a_if_rvalid, a_d_rvalid,
         a_mem_addr, a_mem_funct3, a_mem_wdata, a_if_rdata, a_d_rdata} !== '0) begin
      errors++; $display("FAIL reset_a: outputs not all zero during reset");
    end
    checks++;
    if ({b_if_gnt, b_d_gnt, b_mem_read, b_mem_write, b_busy, b_if_rvalid, b_d_rvalid,
         b_mem_addr, b_mem_funct3, b_mem_wdata, b_if_rdata, b_d_rdata} !== '0) begin
      errors++; $display("FAIL reset_b: outputs not all zero during reset");
    end
    tick();
    checks++;
    if ({a_if_gnt, a_d_gnt, a_busy} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt: got gnt/busy %b, want 000", {a_if_gnt, a_d_gnt, a_busy});
    end
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    tick();
    if_addr = 8'h04; if_req = 1'b1; mem_rdata = 32'h0050_0093;
    #1;
    checks++;
    if ({a_if_gnt, a_d_gnt} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt: got if/d gnt %b, want 10", {a_if_gnt, a_d_gnt});
    end
    tick();
    if_req = 1'b0;
    #1;
    checks++;
    if ({a_mem_read, a_mem_write, a_busy, a_if_gnt} !== 4'b1010 || a_mem_addr !== 8'h04 ||
        a_mem_funct3 !== 3'b010) begin
      errors++; $display("FAIL fetch_bus: got rd/wr/busy/gnt %b addr %h f3 %b, want 1010 04 010",
                         {a_mem_read, a_mem_write, a_busy, a_if_gnt}, a_mem_addr, a_mem_funct3);
    end
    tick();
    checks++;
    if (a_if_rvalid !== 1'b1 || a_if_rdata !== 32'h0050_0093 || a_mem_read !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL fetch_rvalid: got rvalid %b rdata %h rd %b busy %b, want 1 00500093 0 0",
                         a_if_rvalid, a_if_rdata, a_mem_read, a_busy);
    end
    mem_rdata = 32'h1111_2222;
    tick();
    checks++;
    if (a_if_rvalid !== 1'b0 || a_if_rdata !== 32'h0050_0093) begin
      errors++; $display("FAIL fetch_hold: got rvalid %b rdata %h, want 0 00500093", a_if_rvalid, a_if_rdata);
    end
  endtask

  task automatic test_store_then_fetch();
    tick();
    if_req = 1'b1; if_addr = 8'h08;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
    mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({a_if_gnt, a_d_gnt} !== 2'b01) begin
      errors++; $display("FAIL store_gnt: got if/d gnt %b, want 01", {a_if_gnt, a_d_gnt});
    end
    tick();
    d_req = 1'b0;
    #1;
    checks++;
    if ({a_mem_read, a_mem_write, a_if_gnt} !== 3'b010 || a_mem_addr !== 8'h40 ||
        a_mem_wdata !== 32'hDEAD_BEEF || a_mem_funct3 !== 3'b010) begin
      errors++; $display("FAIL store_bus: got rd/wr/gnt %b addr %h wdata %h, want 010 40 deadbeef",
                         {a_mem_read, a_mem_write, a_if_gnt}, a_mem_addr, a_mem_wdata);
    end
    tick();
    checks++;
    if (a_d_rvalid !== 1'b1 || a_d_rdata !== 32'h0 || a_mem_write !== 1'b0 || a_if_gnt !== 1'b1) begin
      errors++; $display("FAIL store_ack: got rvalid %b rdata %h wr %b if_gnt %b, want 1 0 0 1",
                         a_d_rvalid, a_d_rdata, a_mem_write, a_if_gnt);
    end
    tick();
    if_req = 1'b0;
    #1;
    checks++;
    if (a_mem_read !== 1'b1 || a_mem_addr !== 8'h08 || a_d_rvalid !== 1'b0) begin
      errors++; $display("FAIL store_fetch_bus: got rd %b addr %h d_rvalid %b, want 1 08 0",
                         a_mem_read, a_mem_addr, a_d_rvalid);
    end
    tick();
    checks++;
    if (a_if_rvalid !== 1'b1 || a_if_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL store_fetch_data: got rvalid %b rdata %h, want 1 12345678", a_if_rvalid, a_if_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_if;
    int grants;
    exp_if = 10'b10_0001_0000;
    grants = 0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h44; d_funct3 = 3'b010; if_req = 1'b1; if_addr = 8'h0C;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (a_if_gnt && a_d_gnt) begin
        checks++; errors++;
        $display("FAIL burst_both: both gnts high at grant %0d", grants);
      end else if (a_if_gnt || a_d_gnt) begin
        checks++;
        if (a_if_gnt !== exp_if[grants]) begin
          errors++; $display("FAIL burst_seq: grant %0d got if_gnt %b, want %b", grants, a_if_gnt, exp_if[grants]);
        end
        grants++;
      end
      if (grants == 10) break;
      tick();
    end
    checks++;
    if (grants != 10) begin
      errors++; $display("FAIL burst_timeout: got %0d grants, want 10", grants);
    end
    tick();
    d_req = 1'b0; if_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_long_latency();
    rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; d_funct3 = 3'b000; if_req = 1'b0;
    mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({b_if_gnt, b_d_gnt} !== 2'b01) begin
      errors++; $display("FAIL lat3_gnt: got if/d gnt %b, want 01", {b_if_gnt, b_d_gnt});
    end
    tick();
    d_req = 1'b0; if_req = 1'b1; if_addr = 8'h0C;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if ({b_mem_read, b_mem_write, b_busy, b_if_gnt, b_d_gnt, b_d_rvalid} !== 6'b101000 ||
          b_mem_addr !== 8'h10 || b_mem_funct3 !== 3'b000) begin
        errors++; $display("FAIL lat3_hold: cycle %0d got rd/wr/busy/ig/dg/rv %b addr %h, want 101000 10",
                           k, {b_mem_read, b_mem_write, b_busy, b_if_gnt, b_d_gnt, b_d_rvalid}, b_mem_addr);
      end
      tick();
    end
    checks++;
    if (b_d_rvalid !== 1'b1 || b_d_rdata !== 32'hCAFE_F00D || b_mem_read !== 1'b0 || b_if_gnt !== 1'b1) begin
      errors++; $display("FAIL lat3_rvalid: got rvalid %b rdata %h rd %b if_gnt %b, want 1 cafef00d 0 1",
                         b_d_rvalid, b_d_rdata, b_mem_read, b_if_gnt);
    end
  endtask

  task automatic test_reset_mid_access();
    tick();
    if_req = 1'b0;
    #1;
    checks++;
    if (b_mem_read !== 1'b1 || b_mem_addr !== 8'h0C) begin
      errors++; $display("FAIL rstmid_start: got rd %b addr %h, want 1 0c", b_mem_read, b_mem_addr);
    end
    tick();
    rst = 1'b0; if_req = 1'b1;
    #1;
    checks++;
    if ({b_mem_read, b_mem_write, b_busy, b_if_gnt, b_d_gnt} !== 5'b00000 || b_mem_addr !== 8'h00) begin
      errors++; $display("FAIL rstmid_clear: got rd/wr/busy/ig/dg %b addr %h, want 00000 00",
                         {b_mem_read, b_mem_write, b_busy, b_if_gnt, b_d_gnt}, b_mem_addr);
    end
    tick();
    checks++;
    if ({b_busy, b_if_gnt, b_if_rvalid} !== 3'b000) begin
      errors++; $display("FAIL rstmid_held: got busy/gnt/rvalid %b, want 000", {b_busy, b_if_gnt, b_if_rvalid});
    end
    if_req = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (b_if_rvalid !== 1'b0 || b_d_rvalid !== 1'b0 || b_if_rdata !== 32'h0) begin
        errors++; $display("FAIL rstmid_dropped: cycle %0d got rvalid %b/%b if_rdata %h, want 0/0 0",
                           k, b_if_rvalid, b_d_rvalid, b_if_rdata);
      end
    end
    d_req = 1'b1; if_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; d_funct3 = 3'b010;
    mem_rdata = 32'h0BAD_C0DE;
    #1;
    checks++;
    if ({b_if_gnt, b_d_gnt} !== 2'b01) begin
      errors++; $display("FAIL rstmid_regrant: got if/d gnt %b, want 01", {b_if_gnt, b_d_gnt});
    end
    tick();
    d_req = 1'b0; if_req = 1'b0;
    #1;
    checks++;
    if (b_mem_read !== 1'b1 || b_mem_addr !== 8'h20) begin
      errors++; $display("FAIL rstmid_bus: got rd %b addr %h, want 1 20", b_mem_read, b_mem_addr);
    end
    tick();
    tick();
    tick();
    checks++;
    if (b_d_rvalid !== 1'b1 || b_d_rdata !== 32'h0BAD_C0DE) begin
      errors++; $display("FAIL rstmid_data: got rvalid %b rdata %h, want 1 0badc0de", b_d_rvalid, b_d_rdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_store_then_fetch();
    test_back_to_back();
    test_long_latency();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-ported unified instruction/data memory between the IF fetch port and the MEM-stage load/store port.
- Replaces the hard-wired PC/ALU-result address mux and the always-stall-on-data-access policy with a req/gnt/rvalid handshake.
- Supports a configurable memory latency and an anti-starvation limit for instruction fetch.
- Sits between the pipeline core and the memory module.

Parameters:
- ADDR_W, 8, memory byte-address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles the memory control lines are held per access; must be at least 1.
- MAX_D_BURST, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data access request.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid or store acknowledge, one-cycle pulse.
- d_rdata  out  DATA_W  load data; 0 for stores.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_funct3  out  3  to memory.
- mem_addr  out  ADDR_W  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_rdata  in  DATA_W  from memory, combinational read.
- busy  out  1  access in flight.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, owner=IF, cnt=0, streak=0.
  - All registered outputs 0: mem_*, if_rvalid, d_rvalid, if_rdata, d_rdata, busy.
  - if_gnt and d_gnt are forced 0 while rst is low.
  - An in-flight access is dropped; no rvalid is ever produced for it.
- States are IDLE and ACCESS.
- Grant decision, IDLE only (combinational):
  - d_req and if_req both high with streak==MAX_D_BURST: grant IF.
  - Otherwise d_req high: grant data.
  - Otherwise if_req high: grant IF.
  - At most one gnt is high per cycle. gnt is never asserted in ACCESS; requesters hold req and inputs until gnt.
- On grant edge:
  - Latch owner, address, funct3, wdata and we.
  - Drive mem_read = !we and mem_write = we for data; mem_read=1, mem_funct3=3'b010 for IF.
  - Go to ACCESS with cnt=MEM_LAT-1 and busy=1.
- ACCESS:
  - mem_* held stable for exactly MEM_LAT cycles.
  - At cnt==0:
    - Capture mem_rdata (0 for a store) into the owner's rdata register.
    - Clear mem_*; go to IDLE.
    - Set the owner's rvalid for the next cycle only.
  - Otherwise cnt decrements.
- Timing:
  - Latency is request/gnt at cycle N, rvalid and rdata at N+MEM_LAT+1.
  - A new grant may occur in the same cycle as that rvalid pulse, so peak throughput is one access per MEM_LAT+1 cycles.
- rdata registers hold their value until the next completion for that port.
- streak counter:
  - Increments, saturating at MAX_D_BURST, on a data grant while if_req is high.
  - Cleared on any IF grant, and on a data grant with if_req low.
- Boundary cases:
  - Simultaneous req in IDLE: data wins unless streak is saturated.
  - A request dropped before gnt is legal and causes no effect.
  - Address wrap is not handled; addresses pass through unmodified.

Decomposition:
- Shared defines header holds:
  - state encodings ARB_IDLE=1'b0 and ARB_ACCESS=1'b1;
  - owner encodings OWN_IF=1'b0 and OWN_D=1'b1;
  - the funct3 constant for word fetch.
- Single module; no sub-module needed. The latency counter and streak counter are inline registers.

Test Plan:
- MEM_LAT=1, if_req=1 with if_addr=0x04 and mem_rdata=0x00500093 -> if_gnt at cycle 0, mem_read=1 and mem_addr=0x04 at cycle 1, if_rvalid=1 and if_rdata=0x00500093 at cycle 2.
- if_req and d_req both high, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_funct3=3'b010 -> d_gnt first; mem_write=1 for 1 cycle with mem_addr=0x40; d_rvalid pulse with d_rdata=0; if_gnt in the same cycle as that d_rvalid pulse.
- MAX_D_BURST=4, d_req and if_req held high continuously -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
- MEM_LAT=3, d load at addr 0x10 -> mem_read held exactly 3 cycles; d_rvalid at N+4; no gnt during ACCESS even though if_req is high.
- rst pulled low in the 2nd ACCESS cycle (MEM_LAT=3) -> mem_*, busy and gnt go 0 immediately; no rvalid follows; the first request after rst is released is granted normally with streak=0.
